axi4_rd_master: RTL and testbench
=================================

Name: axi4_rd_master

Overview:
- AXI4 read-channel initiator. Converts a simple core-side burst-read request into one AR transaction, then streams the R beats back to the requester.
- Sits between the instruction-fetch/cache-refill logic and the SoC AXI4 slave port, which is the io_slave_* memory model.
- One outstanding transaction at a time.
- No write channels.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, R data width
ID_W, 4, AXI ID width
ARID, 0, constant ID driven on io_master_arid and expected on io_master_rid
TIMEOUT, 1024, watchdog limit in cycles (used only with AXI4_RD_TIMEOUT_EN)

Ports:
clock  in  1  single clock, all logic posedge
reset  in  1  synchronous, active-high reset
req_valid  in  1  read request valid
req_ready  out  1  block can accept request
req_addr  in  ADDR_W  start address
req_len  in  8  beats minus 1 (AXI arlen encoding)
req_size  in  3  bytes per beat, log2 (AXI arsize encoding)
resp_valid  out  1  read beat valid
resp_ready  in  1  requester accepts beat
resp_data  out  DATA_W  beat data
resp_last  out  1  final beat of the burst
resp_err  out  1  beat carries an error (slave or protocol)
io_master_arready  in  1  AR ready
io_master_arvalid  out  1  AR valid
io_master_araddr  out  ADDR_W  AR address
io_master_arid  out  ID_W  AR id
io_master_arlen  out  8  AR length
io_master_arsize  out  3  AR size
io_master_arburst  out  2  AR burst type, always 2'b01 (INCR)
io_master_rready  out  1  R ready
io_master_rvalid  in  1  R valid
io_master_rresp  in  2  R response
io_master_rdata  in  DATA_W  R data
io_master_rlast  in  1  R last
io_master_rid  in  ID_W  R id

Behaviour:
- Reset state: state IDLE; beat counter 0. All outputs 0 except:
  - req_ready=1
  - io_master_arid=ARID
  - io_master_arburst=2'b01
- IDLE:
  - req_ready=1.
  - On req_valid, register addr/len/size, load beat counter=req_len, go to ADDR.
  - The AR fields come from registers only, so no same-cycle AR.
- ADDR:
  - arvalid=1 with registered fields; fields stable until arready.
  - arvalid never drops before arready.
  - On arready, go to DATA.
- DATA:
  - rready=resp_ready, combinational pass-through.
  - resp_valid=rvalid; resp_data=rdata; no added latency.
- Beat accepted (rvalid & rready):
  - Decrement the counter.
  - resp_last=1 when the counter is 0, independent of io_master_rlast.
- resp_err=1 on a beat if any of:
  - rresp != 2'b00
  - rid != ARID
  - rlast=1 while counter != 0 (early last)
  - rlast=0 while counter == 0 (missing last)
- Exit from DATA: go to IDLE on the accepted beat with counter == 0. Transaction length is governed by req_len only; early rlast does not end the burst.
- Beats are never dropped or duplicated under resp_ready backpressure.
- req_ready=0 in ADDR and DATA; a req_valid there is ignored (not queued).
- R beats outside DATA: rready=0, so they are not accepted.
- Reset asserted mid-transaction: return to IDLE next edge and drop all state. The slave side is reset concurrently by the SoC.
- req_len=0: single beat, resp_last=1 on it.
- req_len=255: 256 beats, 8-bit counter, no wrap.

Optional Feature:
- AXI4_RD_TIMEOUT_EN defined:
  - Per-transaction cycle counter, cleared on entry to ADDR and on each accepted R beat.
  - When it reaches TIMEOUT in ADDR or DATA, emit one synthetic beat: resp_valid=1, resp_err=1, resp_last=1, resp_data=0. It waits for resp_ready, then the block returns to IDLE.
  - arvalid is deasserted on timeout. This is the only permitted arvalid drop.
  - Later R beats of the abandoned ID are ignored: rready=0 outside DATA.
- Undefined: no counter, no synthetic beat; the block waits forever.

Test Plan:
- Single beat: req addr=0x3000_0000, len=0, size=3; arready=1, one R beat rdata=0x00000413, rlast=1 -> arvalid for exactly 1 cycle with araddr 0x3000_0000, arlen 0, arsize 3; resp_data=0x00000413, resp_last=1, resp_err=0; req_ready high the following cycle.
- Burst with backpressure: len=3; resp_ready toggling 1,0,1,0; slave holds rvalid -> exactly 4 beats delivered in order, resp_last only on the 4th, no drops or duplicates.
- AR stall: arready held 0 for 5 cycles -> arvalid and araddr/arlen/arsize stable all 5 cycles; transfer to DATA on the 6th edge.
- Errors: rresp=2'b10 on beat 1 of 2 -> that beat resp_err=1, beat 2 resp_err=0. Separately, rlast=1 on beat 1 of len=1 -> resp_err=1 on beat 1, burst still completes after 2 beats.
- Reset mid-burst: assert reset after beat 2 of len=7 -> next cycle state IDLE, req_ready=1, arvalid=0, rready=0.
- With AXI4_RD_TIMEOUT_EN and TIMEOUT=16: arready never asserted -> at cycle 16, arvalid falls and one beat with resp_err=1, resp_last=1, resp_data=0 is emitted; then IDLE.

Source files
------------

// File: rtl/axi4_rd_master.sv
// Purpose: AXI4 read initiator; one core burst request -> one AR, R beats streamed back to the requester.
// Latency: AR issued the cycle after req accept; R beats forwarded combinationally (zero added latency).
// Backpressure: resp_ready drives rready directly; AR fields held stable until arready; one transaction in flight.
//
// Ports: clock/reset (sync, active-high); req_* core request (valid/ready); resp_* beat stream to requester;
//        io_master_ar* AR channel out; io_master_r* R channel in.
// Optional: define AXI4_RD_TIMEOUT_EN to enable a TIMEOUT-cycle watchdog that ends a stuck transaction
//           with one synthetic error beat (resp_err=1, resp_last=1, resp_data=0).
module axi4_rd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int ID_W    = 4,
    parameter int ARID    = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_len,
    input  logic [2:0]        req_size,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,
    output logic              resp_err,
    input  logic              io_master_arready,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [ID_W-1:0]   io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [1:0]        io_master_rresp,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic              io_master_rlast,
    input  logic [ID_W-1:0]   io_master_rid
);

    localparam logic [ID_W-1:0] ARID_V = ID_W'(ARID);

    // S_TOUT is only reachable with the watchdog enabled.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_TOUT = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        len_q, len_d;
    logic [2:0]        size_q, size_d;
    logic [7:0]        cnt_q, cnt_d;     // beats remaining minus one

    logic beat_acc;
    logic cnt_zero;
    logic beat_err;

    assign cnt_zero = (cnt_q == 8'd0);
    assign beat_acc = (state_q == S_DATA) && io_master_rvalid && resp_ready;

    // Burst length is owned by our counter; rlast is only checked against it.
    assign beat_err = (io_master_rresp != 2'b00)
                   || (io_master_rid != ARID_V)
                   || ( io_master_rlast && !cnt_zero)
                   || (!io_master_rlast &&  cnt_zero);

`ifdef AXI4_RD_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_hit;

    // tmo_q counts cycles spent since ADDR entry or the last accepted beat;
    // the TIMEOUT-th such cycle without progress abandons the transaction.
    assign tmo_hit = (tmo_q == TMO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
`ifdef AXI4_RD_TIMEOUT_EN
        tmo_d   = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    len_d   = req_len;
                    size_d  = req_size;
                    cnt_d   = req_len;
                    state_d = S_ADDR;
`ifdef AXI4_RD_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            S_ADDR: begin
                if (io_master_arready) begin
                    state_d = S_DATA;
                end
`ifdef AXI4_RD_TIMEOUT_EN
                tmo_d = tmo_q + 1'b1;
                // A handshake in the same cycle wins: the slave already owns the AR.
                if (!io_master_arready && tmo_hit) begin
                    state_d = S_TOUT;
                end
`endif
            end
            S_DATA: begin
                if (beat_acc) begin
                    if (cnt_zero) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
`ifdef AXI4_RD_TIMEOUT_EN
                if (beat_acc) begin
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_hit) begin
                        state_d = S_TOUT;
                    end
                end
`endif
            end
            S_TOUT: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready         = (state_q == S_IDLE);
        io_master_arvalid = (state_q == S_ADDR);
        io_master_araddr  = addr_q;
        io_master_arid    = ARID_V;
        io_master_arlen   = len_q;
        io_master_arsize  = size_q;
        io_master_arburst = 2'b01;
        io_master_rready  = 1'b0;
        resp_valid        = 1'b0;
        resp_data         = '0;
        resp_last         = 1'b0;
        resp_err          = 1'b0;
        case (state_q)
            S_DATA: begin
                io_master_rready = resp_ready;
                resp_valid       = io_master_rvalid;
                resp_data        = io_master_rdata;
                resp_last        = cnt_zero;
                resp_err         = beat_err;
            end
            S_TOUT: begin
                resp_valid = 1'b1;
                resp_last  = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
`ifdef AXI4_RD_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
`ifdef AXI4_RD_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi4_rd_master.sv
// Purpose: self-checking bench for axi4_rd_master with a scripted AXI slave and a beat-level reference model.
// Latency: expectations are per-beat and per-AR-cycle, derived from request length and slave script.
// Backpressure: requester ready is driven as always-on, strict toggle, or bounded random.
module tb_axi4_rd_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 64;
    localparam int ID_W    = 4;
    localparam int ARID    = 0;
    localparam int TIMEOUT = 16;
    localparam logic [ID_W-1:0] ARID_V = ID_W'(ARID);

    logic              clock = 1'b0;
    logic              reset;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [7:0]        req_len;
    logic [2:0]        req_size;
    logic              resp_valid, resp_ready, resp_last, resp_err;
    logic [DATA_W-1:0] resp_data;
    logic              io_master_arready, io_master_arvalid;
    logic [ADDR_W-1:0] io_master_araddr;
    logic [ID_W-1:0]   io_master_arid;
    logic [7:0]        io_master_arlen;
    logic [2:0]        io_master_arsize;
    logic [1:0]        io_master_arburst;
    logic              io_master_rready, io_master_rvalid, io_master_rlast;
    logic [1:0]        io_master_rresp;
    logic [DATA_W-1:0] io_master_rdata;
    logic [ID_W-1:0]   io_master_rid;

    always #5 clock = ~clock;

    axi4_rd_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ARID(ARID), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_size(req_size),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last), .resp_err(resp_err),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
        .io_master_rvalid(io_master_rvalid), .io_master_rresp(io_master_rresp),
        .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast),
        .io_master_rid(io_master_rid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Slave script: beats the slave will offer, in order
    logic [DATA_W-1:0] sl_data[$];
    logic [1:0]        sl_resp[$];
    logic [ID_W-1:0]   sl_id[$];
    logic              sl_last[$];

    // Reference model output
    logic [DATA_W-1:0] exp_data[$];
    logic              exp_last[$];
    logic              exp_err[$];

    // Observations
    logic [DATA_W-1:0] ob_data[$];
    logic              ob_last[$];
    logic              ob_err[$];
    int                ob_ar_cycles;
    int                ob_ar_unstable;
    logic [ADDR_W-1:0] ob_araddr;
    logic [7:0]        ob_arlen;
    logic [2:0]        ob_arsize;
    logic [ID_W-1:0]   ob_arid;
    logic [1:0]        ob_arburst;
    logic              ob_req_rdy_start;
    logic              ob_hung;

    task automatic quiet();
        req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
        resp_ready = 1'b0; io_master_arready = 1'b0; io_master_rvalid = 1'b0;
        io_master_rresp = 2'b00; io_master_rdata = '0; io_master_rlast = 1'b0; io_master_rid = '0;
    endtask

    task automatic clear_script();
        sl_data.delete(); sl_resp.delete(); sl_id.delete(); sl_last.delete();
    endtask

    task automatic push_beat(input logic [DATA_W-1:0] d, input logic [1:0] r,
                             input logic [ID_W-1:0] id, input logic l);
        sl_data.push_back(d); sl_resp.push_back(r); sl_id.push_back(id); sl_last.push_back(l);
    endtask

    task automatic script_good(input int len);
        for (int i = 0; i <= len; i++)
            push_beat({$urandom, $urandom}, 2'b00, ARID_V, i == len);
    endtask

    // Model: exactly len+1 beats; last only on the final one; error on bad
    // response, wrong id, or rlast disagreeing with the beat position.
    task automatic build_expected(input int len);
        exp_data.delete(); exp_last.delete(); exp_err.delete();
        for (int i = 0; i <= len; i++) begin
            exp_data.push_back(sl_data[i]);
            exp_last.push_back(i == len);
            exp_err.push_back(sl_resp[i] != 2'b00 || sl_id[i] != ARID_V || sl_last[i] != (i == len));
        end
    endtask

    // Drives one request and plays the slave/requester; records what it sees.
    // rdy_mode: 0 always ready, 1 toggle per cycle, 2 random (at most 2 low in a row).
    task automatic run_burst(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input int ar_wait, input int rdy_mode,
                             input bit gaps, input int stop_after);
        int  sidx = 0;
        int  ar_seen = 0;
        int  cyc = 0;
        int  lowrun = 0;
        int  gaprun = 0;
        bit  ar_done = 1'b0;
        bit  done = 1'b0;
        bit  first_ar = 1'b1;
        bit  adv;
        ob_data.delete(); ob_last.delete(); ob_err.delete();
        ob_ar_cycles = 0; ob_ar_unstable = 0;
        @(posedge clock); #1;
        ob_req_rdy_start = req_ready;
        req_valid = 1'b1; req_addr = addr; req_len = len; req_size = size;
        @(posedge clock); #1;
        req_addr = $urandom; req_len = 8'($urandom); req_size = 3'($urandom);
        while (!done && cyc < 3000) begin
            // Requests while busy must be ignored
            req_valid = req_ready ? 1'b0 : 1'($urandom_range(0, 1));
            io_master_arready = (ar_seen >= ar_wait);
            if (!io_master_rvalid && ar_done && sidx < sl_data.size()) begin
                if (gaps && gaprun < 2 && $urandom_range(0, 2) == 0) gaprun++;
                else begin gaprun = 0; io_master_rvalid = 1'b1; end
            end
            if (io_master_rvalid) begin
                io_master_rdata = sl_data[sidx]; io_master_rresp = sl_resp[sidx];
                io_master_rid = sl_id[sidx]; io_master_rlast = sl_last[sidx];
            end
            case (rdy_mode)
                0:       resp_ready = 1'b1;
                1:       resp_ready = (cyc % 2 == 0);
                default: resp_ready = (lowrun >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
            endcase
            lowrun = resp_ready ? 0 : lowrun + 1;
            #1;
            if (io_master_arvalid) begin
                if (first_ar) begin
                    ob_araddr = io_master_araddr; ob_arlen = io_master_arlen;
                    ob_arsize = io_master_arsize; ob_arid = io_master_arid;
                    ob_arburst = io_master_arburst; first_ar = 1'b0;
                end else if (io_master_araddr !== ob_araddr || io_master_arlen !== ob_arlen ||
                             io_master_arsize !== ob_arsize) begin
                    ob_ar_unstable++;
                end
                ob_ar_cycles++; ar_seen++;
                if (io_master_arready) ar_done = 1'b1;
            end
            if (resp_valid && resp_ready) begin
                ob_data.push_back(resp_data); ob_last.push_back(resp_last); ob_err.push_back(resp_err);
                if (resp_last || ob_data.size() == stop_after) done = 1'b1;
            end
            adv = io_master_rvalid && io_master_rready;
            if (!done) begin
                @(posedge clock); #1;
                if (adv) begin sidx++; io_master_rvalid = 1'b0; end
            end
            cyc++;
        end
        ob_hung = !done;
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1; resp_ready = 1'b1; io_master_rvalid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (io_master_arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid: got %b want 0", io_master_arvalid); end
        n_cmp++; if (io_master_rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready: got %b want 0", io_master_rready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_cmp++; if (io_master_arid !== ARID_V) begin n_bad++; $display("FAIL reset_arid: got %0h want %0h", io_master_arid, ARID_V); end
        n_cmp++; if (io_master_arburst !== 2'b01) begin n_bad++; $display("FAIL reset_arburst: got %b want 01", io_master_arburst); end
        n_cmp++; if (io_master_araddr !== '0 || io_master_arlen !== 8'd0) begin n_bad++; $display("FAIL reset_ar_fields: got addr=%0h len=%0d want 0", io_master_araddr, io_master_arlen); end
        quiet();
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        clear_script();
        push_beat(64'h0000_0000_0000_0413, 2'b00, ARID_V, 1'b1);
        build_expected(0);
        run_burst(32'h3000_0000, 8'd0, 3'd3, 0, 0, 1'b0, -1);
        n_cmp++; if (ob_hung !== 1'b0) begin n_bad++; $display("FAIL single_done: hung=%b want 0", ob_hung); end
        n_cmp++; if (ob_req_rdy_start !== 1'b1) begin n_bad++; $display("FAIL single_req_ready_idle: got %b want 1", ob_req_rdy_start); end
        n_cmp++; if (ob_ar_cycles !== 1) begin n_bad++; $display("FAIL single_arvalid_cycles: got %0d want 1", ob_ar_cycles); end
        n_cmp++; if (ob_araddr !== 32'h3000_0000 || ob_arlen !== 8'd0 || ob_arsize !== 3'd3) begin n_bad++; $display("FAIL single_ar_fields: got addr=%0h len=%0d size=%0d want 30000000/0/3", ob_araddr, ob_arlen, ob_arsize); end
        n_cmp++; if (ob_arid !== ARID_V || ob_arburst !== 2'b01) begin n_bad++; $display("FAIL single_arid_burst: got id=%0h burst=%b want %0h/01", ob_arid, ob_arburst, ARID_V); end
        n_cmp++; if (ob_data.size() !== 1) begin n_bad++; $display("FAIL single_beat_count: got %0d want 1", ob_data.size()); end
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL single_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        @(posedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_req_ready_after: got %b want 1", req_ready); end
        quiet();
    endtask

    task automatic test_burst_backpressure();
        clear_script();
        script_good(3);
        build_expected(3);
        run_burst($urandom, 8'd3, 3'd3, 0, 1, 1'b0, -1);
        n_cmp++; if (ob_hung !== 1'b0) begin n_bad++; $display("FAIL bp_done: hung=%b want 0", ob_hung); end
        n_cmp++; if (ob_data.size() !== 4) begin n_bad++; $display("FAIL bp_beat_count: got %0d want 4", ob_data.size()); end
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL bp_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        @(posedge clock); #1;
        quiet();
    endtask

    task automatic test_ar_stall();
        clear_script();
        script_good(1);
        build_expected(1);
        run_burst(32'h8000_1230, 8'd1, 3'd2, 5, 0, 1'b0, -1);
        n_cmp++; if (ob_ar_cycles !== 6) begin n_bad++; $display("FAIL stall_arvalid_cycles: got %0d want 6", ob_ar_cycles); end
        n_cmp++; if (ob_ar_unstable !== 0) begin n_bad++; $display("FAIL stall_ar_stable: got %0d changed cycles want 0", ob_ar_unstable); end
        n_cmp++; if (ob_araddr !== 32'h8000_1230 || ob_arlen !== 8'd1 || ob_arsize !== 3'd2) begin n_bad++; $display("FAIL stall_ar_fields: got addr=%0h len=%0d size=%0d want 80001230/1/2", ob_araddr, ob_arlen, ob_arsize); end
        n_cmp++; if (ob_data.size() !== 2) begin n_bad++; $display("FAIL stall_beat_count: got %0d want 2", ob_data.size()); end
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL stall_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        @(posedge clock); #1;
        quiet();
    endtask

    task automatic test_errors();
        // Slave error on beat 1 of 2
        clear_script();
        push_beat(64'hAAAA_0001, 2'b10, ARID_V, 1'b0);
        push_beat(64'hAAAA_0002, 2'b00, ARID_V, 1'b1);
        build_expected(1);
        run_burst(32'h100, 8'd1, 3'd3, 1, 0, 1'b0, -1);
        n_cmp++; if (ob_data.size() !== 2) begin n_bad++; $display("FAIL err_resp_count: got %0d want 2", ob_data.size()); end
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL err_resp_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        @(posedge clock); #1;
        quiet();
        // Early rlast on beat 1 of 2: flagged, burst still runs to 2 beats
        clear_script();
        push_beat(64'hBBBB_0001, 2'b00, ARID_V, 1'b1);
        push_beat(64'hBBBB_0002, 2'b00, ARID_V, 1'b1);
        build_expected(1);
        run_burst(32'h200, 8'd1, 3'd3, 0, 0, 1'b0, -1);
        n_cmp++; if (ob_data.size() !== 2) begin n_bad++; $display("FAIL err_early_last_count: got %0d want 2", ob_data.size()); end
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL err_early_last_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        @(posedge clock); #1;
        quiet();
    endtask

    task automatic test_reset_mid_burst();
        clear_script();
        script_good(7);
        build_expected(7);
        run_burst(32'h4000, 8'd7, 3'd3, 0, 0, 1'b0, 2);
        n_cmp++; if (ob_data.size() !== 2) begin n_bad++; $display("FAIL rstmid_beat_count: got %0d want 2", ob_data.size()); end
        for (int i = 0; i < 2 && i < ob_data.size(); i++) begin
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== 1'b0) begin n_bad++; $display("FAIL rstmid_beat %0d: got data=%0h last=%b want data=%0h last=0", i, ob_data[i], ob_last[i], exp_data[i]); end
        end
        @(posedge clock); #1;
        reset = 1'b1; resp_ready = 1'b1; io_master_rvalid = 1'b1;
        @(posedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (io_master_arvalid !== 1'b0) begin n_bad++; $display("FAIL rstmid_arvalid: got %b want 0", io_master_arvalid); end
        n_cmp++; if (io_master_rready !== 1'b0) begin n_bad++; $display("FAIL rstmid_rready: got %b want 0", io_master_rready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_resp_valid: got %b want 0", resp_valid); end
        quiet();
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 14; t++) begin
            int len;
            len = $urandom_range(0, 12);
            clear_script();
            for (int i = 0; i <= len; i++) begin
                logic [1:0]      r;
                logic [ID_W-1:0] id;
                logic            l;
                r  = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                id = ($urandom_range(0, 7) == 0) ? (ARID_V ^ ID_W'($urandom_range(1, 15))) : ARID_V;
                l  = (i == len);
                if ($urandom_range(0, 7) == 0) l = !l;
                push_beat({$urandom, $urandom}, r, id, l);
            end
            build_expected(len);
            run_burst($urandom, 8'(len), 3'($urandom_range(0, 3)), $urandom_range(0, 3), 2, 1'b1, -1);
            n_cmp++; if (ob_data.size() !== exp_data.size()) begin n_bad++; $display("FAIL rand%0d_beat_count: got %0d want %0d", t, ob_data.size(), exp_data.size()); end
            for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
                n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL rand%0d_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", t, i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
            end
            @(posedge clock); #1;
            n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rand%0d_req_ready_after: got %b want 1", t, req_ready); end
            quiet();
        end
    endtask

    task automatic test_max_len();
        int n_last;
        clear_script();
        script_good(255);
        build_expected(255);
        run_burst(32'h9000_0000, 8'd255, 3'd3, 0, 0, 1'b0, -1);
        n_cmp++; if (ob_data.size() !== 256) begin n_bad++; $display("FAIL maxlen_beat_count: got %0d want 256", ob_data.size()); end
        n_last = 0;
        for (int i = 0; i < exp_data.size() && i < ob_data.size(); i++) begin
            if (ob_last[i] === 1'b1) n_last++;
            n_cmp++; if (ob_data[i] !== exp_data[i] || ob_last[i] !== exp_last[i] || ob_err[i] !== exp_err[i]) begin n_bad++; $display("FAIL maxlen_beat %0d: got data=%0h last=%b err=%b want data=%0h last=%b err=%b", i, ob_data[i], ob_last[i], ob_err[i], exp_data[i], exp_last[i], exp_err[i]); end
        end
        n_cmp++; if (n_last !== 1) begin n_bad++; $display("FAIL maxlen_last_count: got %0d want 1", n_last); end
        @(posedge clock); #1;
        quiet();
    endtask

`ifdef AXI4_RD_TIMEOUT_EN
    task automatic test_timeout();
        clear_script();
        run_burst(32'h5000, 8'd3, 3'd3, 100000, 0, 1'b0, -1);
        n_cmp++; if (ob_ar_cycles !== TIMEOUT) begin n_bad++; $display("FAIL tmo_arvalid_cycles: got %0d want %0d", ob_ar_cycles, TIMEOUT); end
        n_cmp++; if (ob_data.size() !== 1) begin n_bad++; $display("FAIL tmo_beat_count: got %0d want 1", ob_data.size()); end
        if (ob_data.size() > 0) begin
            n_cmp++; if (ob_data[0] !== '0 || ob_last[0] !== 1'b1 || ob_err[0] !== 1'b1) begin n_bad++; $display("FAIL tmo_beat: got data=%0h last=%b err=%b want 0/1/1", ob_data[0], ob_last[0], ob_err[0]); end
        end
        @(posedge clock); #1;
        n_cmp++; if (req_ready !== 1'b1 || io_master_arvalid !== 1'b0) begin n_bad++; $display("FAIL tmo_idle_after: got req_ready=%b arvalid=%b want 1/0", req_ready, io_master_arvalid); end
        quiet();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        quiet();
        reset = 1'b1;
        test_reset();
        test_single_beat();
        test_burst_backpressure();
        test_ar_stall();
        test_errors();
        test_reset_mid_burst();
        test_random();
        test_max_len();
`ifdef AXI4_RD_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
